// File: rtl/general_defines.sv
`default_nettype none
// ============================================================================
// Package     : general_defines
// Description : Shared widths and types for the reorder-buffer slice. Holds
//               the ROB geometry, architectural/physical/PC index widths and
//               the commit controller's state and occupancy types.
// Revision    : 1.0 - initial release
// ============================================================================
package general_defines;

  localparam int ROB_LENGTH      = 8;
  localparam int ROB_IDX_W       = 3;
  localparam int INSTR_MEM_IDX_W = 8;
  localparam int ARCH_REG_IDX_W  = 5;
  localparam int PHYS_REG_IDX_W  = 6;

  // Commit controller state: normal operation, or the single flush cycle
  // that follows a mispredicted retirement.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rob_cmt_state_t;

  // Occupancy needs one extra bit so that a full ROB is distinguishable
  // from an empty one.
  typedef logic [ROB_IDX_W:0] rob_cnt_t;

endpackage : general_defines
`default_nettype wire

// File: rtl/rob_commit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : rob_commit_ctrl_if
// Description : Bundle between the ROB commit controller and its neighbours
//               (rename allocation, execution completion, storage array head
//               read port, retirement consumer, fetch redirect).
//   slave  modport : the controller side.
//   master modport : the environment side (rename/exec/storage/commit).
// Revision    : 1.0 - initial release
// ============================================================================
interface rob_commit_ctrl_if
  import general_defines::*;
#(
  parameter int IDX_W = ROB_IDX_W
) ();

  // allocation
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic                       rob_write;
  logic [IDX_W-1:0]           rob_tail;
  logic [IDX_W-1:0]           rob_head;
  // completion
  logic                       exec_valid;
  logic [IDX_W-1:0]           exec_rob_idx;
  logic                       exec_actual_taken;
  logic [INSTR_MEM_IDX_W-1:0] exec_actual_target;
  // storage head read data
  logic [INSTR_MEM_IDX_W-1:0] head_pc;
  logic [ARCH_REG_IDX_W-1:0]  head_logical_rd;
  logic [PHYS_REG_IDX_W-1:0]  head_phys_rd;
  logic                       head_is_store;
  logic                       head_is_branch;
  logic                       head_pred_taken;
  logic [INSTR_MEM_IDX_W-1:0] head_pred_target;
  // retirement
  logic                       commit_valid;
  logic                       commit_ready;
  logic [ARCH_REG_IDX_W-1:0]  commit_logical_rd;
  logic [PHYS_REG_IDX_W-1:0]  commit_phys_rd;
  logic                       commit_is_store;
  // recovery and status
  logic                       flush;
  logic [INSTR_MEM_IDX_W-1:0] redirect_pc;
  logic [IDX_W:0]             count;
  logic                       empty;
  logic                       full;

  modport slave (
    input  alloc_valid, exec_valid, exec_rob_idx, exec_actual_taken,
           exec_actual_target, head_pc, head_logical_rd, head_phys_rd,
           head_is_store, head_is_branch, head_pred_taken, head_pred_target,
           commit_ready,
    output alloc_ready, rob_write, rob_tail, rob_head, commit_valid,
           commit_logical_rd, commit_phys_rd, commit_is_store, flush,
           redirect_pc, count, empty, full
  );

  modport master (
    output alloc_valid, exec_valid, exec_rob_idx, exec_actual_taken,
           exec_actual_target, head_pc, head_logical_rd, head_phys_rd,
           head_is_store, head_is_branch, head_pred_taken, head_pred_target,
           commit_ready,
    input  alloc_ready, rob_write, rob_tail, rob_head, commit_valid,
           commit_logical_rd, commit_phys_rd, commit_is_store, flush,
           redirect_pc, count, empty, full
  );

endinterface : rob_commit_ctrl_if
`default_nettype wire

// File: rtl/rob_commit_ctrl_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr_ctr
// Description : Modulo-DEPTH pointer. clr returns it to 0 and has priority
//               over inc; inc advances it, wrapping DEPTH-1 -> 0.
//   clk, rst (sync, active-low), inc, clr -> ptr [IDX_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr_ctr #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] ptr
);

  localparam logic [IDX_W-1:0] c_last = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] c_one  = IDX_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == c_last) ? '0 : ptr + c_one;
    end
  end

endmodule : rob_ptr_ctr
`default_nettype wire

// File: rtl/rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rob_commit_ctrl
// Description : Allocation, completion-tracking and in-order retirement
//               controller for the reorder-buffer storage array. Raises a
//               one-cycle flush with a redirect PC when a mispredicted branch
//               retires.
//   clk           : clock, rising edge
//   rst           : synchronous, active-low reset
//   bus (slave)   : alloc/rob_* storage control, exec_* completion,
//                   head_* storage read data, commit_* retirement,
//                   flush/redirect_pc, count/empty/full status
// Build option: ROB_BRANCH_RECOVERY_EN compiles in mispredict detection, the
//               FLUSH state and per-entry resolved-branch storage. Without
//               it, flush/redirect_pc are tied to 0 and branches retire
//               like any other entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_commit_ctrl
  import general_defines::*;
#(
  parameter int DEPTH = ROB_LENGTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  rob_commit_ctrl_if.slave  bus
);

  localparam logic [IDX_W:0] c_depth = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] c_one   = (IDX_W+1)'(1);

  rob_cmt_state_t   r_state;
  rob_cmt_state_t   w_state_nxt;
  logic [IDX_W:0]   r_count;
  logic [DEPTH-1:0] r_done;

  logic             w_run;
  logic             w_full;
  logic             w_empty;
  logic             w_alloc;
  logic             w_retire;
  logic             w_mispred;
  logic             w_flush_now;
  logic             w_exec_hit;
  logic [IDX_W:0]   w_exec_off;

  // ---------------------------------------------------------------- status
  assign w_run   = (r_state == RUN);
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // alloc_ready looks only at registered state, so a retirement in a full
  // cycle cannot open allocation until the following cycle.
  assign bus.alloc_ready  = w_run & ~w_full;
  assign w_alloc          = bus.alloc_valid & bus.alloc_ready;
  assign bus.rob_write    = w_alloc;

  assign bus.commit_valid = w_run & ~w_empty & r_done[bus.rob_head];
  assign w_retire         = bus.commit_valid & bus.commit_ready;
  assign w_flush_now      = w_retire & w_mispred;

  assign bus.commit_logical_rd = bus.head_logical_rd;
  assign bus.commit_phys_rd    = bus.head_phys_rd;
  assign bus.commit_is_store   = bus.head_is_store;

  assign bus.count = r_count;
  assign bus.empty = w_empty;
  assign bus.full  = w_full;

  // ------------------------------------------------------------ completion
  // Distance of the completing index from head, modulo DEPTH; the index is
  // in flight only when that distance is below the occupancy. Indices at or
  // beyond DEPTH are rejected outright for non-power-of-two depths.
  always_comb begin
    w_exec_off = '0;
    if (bus.exec_rob_idx >= bus.rob_head) begin
      w_exec_off = {1'b0, bus.exec_rob_idx} - {1'b0, bus.rob_head};
    end else begin
      w_exec_off = {1'b0, bus.exec_rob_idx} + c_depth - {1'b0, bus.rob_head};
    end
  end

  assign w_exec_hit = bus.exec_valid & w_run &
                      ({1'b0, bus.exec_rob_idx} < c_depth) &
                      (w_exec_off < r_count);

  // -------------------------------------------------------------- pointers
  rob_ptr_ctr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_retire),
    .clr (w_flush_now),
    .ptr (bus.rob_head)
  );

  rob_ptr_ctr #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_alloc),
    .clr (w_flush_now),
    .ptr (bus.rob_tail)
  );

  // ----------------------------------------------------- occupancy / done
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
      r_done  <= '0;
    end else if (w_flush_now) begin
      r_count <= '0;
      r_done  <= '0;
    end else begin
      if (w_alloc && !w_retire) begin
        r_count <= r_count + c_one;
      end else if (!w_alloc && w_retire) begin
        r_count <= r_count - c_one;
      end
      if (w_alloc) begin
        r_done[bus.rob_tail] <= 1'b0;
      end
      if (w_exec_hit) begin
        r_done[bus.exec_rob_idx] <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_flush_now) w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // ------------------------------------------------------ branch recovery
`ifdef ROB_BRANCH_RECOVERY_EN
  logic [DEPTH-1:0]           r_act_taken;
  logic [INSTR_MEM_IDX_W-1:0] r_act_target [DEPTH];
  logic [INSTR_MEM_IDX_W-1:0] r_redirect_pc;
  logic                       w_head_taken;
  logic [INSTR_MEM_IDX_W-1:0] w_head_target;

  // Resolved outcome is only meaningful once done is set, so no reset.
  always_ff @(posedge clk) begin
    if (w_exec_hit) begin
      r_act_taken[bus.exec_rob_idx]  <= bus.exec_actual_taken;
      r_act_target[bus.exec_rob_idx] <= bus.exec_actual_target;
    end
  end

  assign w_head_taken  = r_act_taken[bus.rob_head];
  assign w_head_target = r_act_target[bus.rob_head];

  // Target only matters when the branch was actually taken.
  assign w_mispred = bus.head_is_branch &
                     ((w_head_taken != bus.head_pred_taken) |
                      (w_head_taken & (w_head_target != bus.head_pred_target)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_redirect_pc <= '0;
    end else if (w_flush_now) begin
      r_redirect_pc <= w_head_taken ? w_head_target
                                    : bus.head_pc + INSTR_MEM_IDX_W'(1);
    end
  end

  assign bus.flush       = (r_state == FLUSH);
  assign bus.redirect_pc = r_redirect_pc;
`else
  logic w_unused_ok;

  assign w_mispred       = 1'b0;
  assign bus.flush       = 1'b0;
  assign bus.redirect_pc = '0;
  assign w_unused_ok     = ^{bus.exec_actual_taken, bus.exec_actual_target,
                             bus.head_pc, bus.head_is_branch,
                             bus.head_pred_taken, bus.head_pred_target};
`endif

endmodule : rob_commit_ctrl
`default_nettype wire

// File: tb/tb_rob_commit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_commit_ctrl
// Description : Self-checking bench for rob_commit_ctrl (DEPTH = 8). Keeps a
//               queue-based model of in-flight entries, drives directed
//               scenarios and a randomized run, and compares DUT outputs
//               against the model. Recovery expectations follow whether
//               ROB_BRANCH_RECOVERY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_commit_ctrl;
  import general_defines::*;

  localparam int DEPTH = 8;
`ifdef ROB_BRANCH_RECOVERY_EN
  localparam bit RECOV = 1'b1;
`else
  localparam bit RECOV = 1'b0;
`endif

  typedef struct {
    int         idx;
    bit         done;
    bit         at;
    logic [7:0] atgt;
    logic [7:0] pc;
    logic [4:0] lrd;
    logic [5:0] prd;
    bit         st;
    bit         br;
    bit         pt;
    logic [7:0] ptgt;
  } ent_t;

  logic clk;
  logic rst;
  rob_commit_ctrl_if #(.IDX_W(3)) bus ();

  rob_commit_ctrl #(.DEPTH(DEPTH), .IDX_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // storage array model, read at the DUT's head pointer
  logic [7:0] mem_pc   [DEPTH];
  logic [4:0] mem_lrd  [DEPTH];
  logic [5:0] mem_prd  [DEPTH];
  logic       mem_st   [DEPTH];
  logic       mem_br   [DEPTH];
  logic       mem_pt   [DEPTH];
  logic [7:0] mem_ptgt [DEPTH];

  assign bus.head_pc          = mem_pc[bus.rob_head];
  assign bus.head_logical_rd  = mem_lrd[bus.rob_head];
  assign bus.head_phys_rd     = mem_prd[bus.rob_head];
  assign bus.head_is_store    = mem_st[bus.rob_head];
  assign bus.head_is_branch   = mem_br[bus.rob_head];
  assign bus.head_pred_taken  = mem_pt[bus.rob_head];
  assign bus.head_pred_target = mem_ptgt[bus.rob_head];

  // reference model
  ent_t       m_q[$];
  int         m_head, m_tail;
  bit         m_fl;
  logic [7:0] m_redir;

  // payload for the next allocation
  logic [7:0] p_pc, p_ptgt;
  logic [4:0] p_lrd;
  logic [5:0] p_prd;
  bit         p_st, p_br, p_pt;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic bit e_alloc_ready();
    return !m_fl && (m_q.size() < DEPTH);
  endfunction

  function automatic bit e_commit_valid();
    return !m_fl && (m_q.size() > 0) && m_q[0].done;
  endfunction

  // Advance one clock, updating the model from the inputs presented now.
  task automatic step();
    bit         do_alloc, do_ret, misp, rst_v, ex_t;
    int         hp;
    logic [7:0] ex_g;
    ent_t       e;
    do_alloc = bus.alloc_valid && e_alloc_ready();
    do_ret   = bus.commit_ready && e_commit_valid();
    rst_v    = rst;
    ex_t     = bus.exec_actual_taken;
    ex_g     = bus.exec_actual_target;
    hp       = -1;
    if (!m_fl && bus.exec_valid)
      for (int i = 0; i < m_q.size(); i++)
        if (m_q[i].idx == int'(bus.exec_rob_idx)) hp = i;
    misp = 1'b0;
    if (do_ret && RECOV)
      misp = m_q[0].br && ((m_q[0].at != m_q[0].pt) ||
                           (m_q[0].at && (m_q[0].atgt != m_q[0].ptgt)));
    @(posedge clk);
    if (!rst_v) begin
      m_q.delete(); m_head = 0; m_tail = 0; m_fl = 1'b0; m_redir = 8'h00;
    end else if (m_fl) begin
      m_fl = 1'b0;
    end else if (misp) begin
      m_redir = m_q[0].at ? m_q[0].atgt : m_q[0].pc + 8'd1;
      m_q.delete(); m_head = 0; m_tail = 0; m_fl = 1'b1;
    end else begin
      if (hp >= 0) begin
        m_q[hp].done = 1'b1; m_q[hp].at = ex_t; m_q[hp].atgt = ex_g;
      end
      if (do_ret) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % DEPTH;
      end
      if (do_alloc) begin
        e = '{idx: m_tail, done: 1'b0, at: 1'b0, atgt: 8'h00, pc: p_pc,
              lrd: p_lrd, prd: p_prd, st: p_st, br: p_br, pt: p_pt, ptgt: p_ptgt};
        m_q.push_back(e);
        mem_pc[m_tail] = p_pc;   mem_lrd[m_tail] = p_lrd; mem_prd[m_tail] = p_prd;
        mem_st[m_tail] = p_st;   mem_br[m_tail]  = p_br;  mem_pt[m_tail]  = p_pt;
        mem_ptgt[m_tail] = p_ptgt;
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = 1'b0; bus.exec_valid = 1'b0; bus.exec_rob_idx = '0;
    bus.exec_actual_taken = 1'b0; bus.exec_actual_target = '0;
    bus.commit_ready = 1'b0;
    p_pc = 8'h00; p_lrd = 5'd0; p_prd = 6'd0; p_st = 1'b0;
    p_br = 1'b0; p_pt = 1'b0; p_ptgt = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0; step(); step();
    rst = 1'b1; #1;
  endtask

  // Allocate one entry with a simple non-branch payload keyed on tail.
  task automatic alloc_plain(input int n);
    for (int i = 0; i < n; i++) begin
      bus.alloc_valid = 1'b1;
      p_br = 1'b0; p_lrd = 5'(m_tail + 1); p_prd = 6'(m_tail + 20);
      p_st = m_tail[0];
      step();
    end
    bus.alloc_valid = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    n_chk++; if (bus.redirect_pc !== 8'h00) begin n_fail++; $display("FAIL reset_redirect: got %h want 00", bus.redirect_pc); end
    n_chk++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b want 1", bus.alloc_ready); end
    n_chk++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %b want 0", bus.commit_valid); end
    n_chk++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full: got %b%b want 10", bus.empty, bus.full); end
    n_chk++; if (bus.count !== 4'd0 || bus.rob_head !== 3'd0 || bus.rob_tail !== 3'd0) begin n_fail++; $display("FAIL reset_ptrs: got cnt %0d h %0d t %0d want 0 0 0", bus.count, bus.rob_head, bus.rob_tail); end
  endtask

  task automatic test_fill();
    do_reset();
    alloc_plain(DEPTH);
    n_chk++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", bus.full); end
    n_chk++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_alloc_ready: got %b want 0", bus.alloc_ready); end
    n_chk++; if (bus.count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d want 8", bus.count); end
    n_chk++; if (bus.rob_tail !== 3'd0) begin n_fail++; $display("FAIL fill_tail_wrap: got %0d want 0", bus.rob_tail); end
  endtask

  task automatic test_out_of_order();
    int order[3] = '{2, 1, 0};
    bus.commit_ready = 1'b1;
    foreach (order[k]) begin
      bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'(order[k]); #1;
      n_chk++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early_commit idx %0d: got %b want 0", order[k], bus.commit_valid); end
      step();
    end
    bus.exec_valid = 1'b0; #1;
    for (int h = 0; h < 3; h++) begin
      n_chk++; if (bus.commit_valid !== 1'b1 || bus.rob_head !== 3'(h)) begin n_fail++; $display("FAIL ooo_retire %0d: got v %b head %0d want v 1 head %0d", h, bus.commit_valid, bus.rob_head, h); end
      n_chk++; if (bus.commit_logical_rd !== 5'(h + 1)) begin n_fail++; $display("FAIL ooo_lrd %0d: got %0d want %0d", h, bus.commit_logical_rd, h + 1); end
      step();
    end
    n_chk++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd5) begin n_fail++; $display("FAIL ooo_stop: got v %b cnt %0d want v 0 cnt 5", bus.commit_valid, bus.count); end
    bus.commit_ready = 1'b0; #1;
  endtask

  task automatic test_full_retire_alloc();
    do_reset();
    alloc_plain(DEPTH);
    bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'd0; step();
    bus.exec_valid = 1'b0; bus.alloc_valid = 1'b1; bus.commit_ready = 1'b1; #1;
    n_chk++; if (bus.alloc_ready !== 1'b0 || bus.rob_write !== 1'b0) begin n_fail++; $display("FAIL fra_c1_alloc: got rdy %b wr %b want 0 0", bus.alloc_ready, bus.rob_write); end
    n_chk++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL fra_c1_commit: got %b want 1", bus.commit_valid); end
    step();
    n_chk++; if (bus.count !== 4'd7) begin n_fail++; $display("FAIL fra_c2_count: got %0d want 7", bus.count); end
    n_chk++; if (bus.rob_write !== 1'b1 || bus.rob_tail !== 3'd0) begin n_fail++; $display("FAIL fra_c2_write: got wr %b tail %0d want 1 0", bus.rob_write, bus.rob_tail); end
    bus.commit_ready = 1'b0; step();
    n_chk++; if (bus.count !== 4'd8 || bus.rob_tail !== 3'd1) begin n_fail++; $display("FAIL fra_c3: got cnt %0d tail %0d want 8 1", bus.count, bus.rob_tail); end
    bus.alloc_valid = 1'b0; #1;
  endtask

  // One branch at pc 0x10 resolved as given; retires, then checks recovery.
  task automatic test_mispredict(input bit pt, input logic [7:0] ptgt,
                                 input bit at, input logic [7:0] atgt,
                                 input logic [7:0] want_pc);
    do_reset();
    bus.alloc_valid = 1'b1; p_pc = 8'h10; p_br = 1'b1; p_pt = pt; p_ptgt = ptgt;
    p_lrd = 5'd9; p_prd = 6'd33; step();
    bus.alloc_valid = 1'b0; bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'd0;
    bus.exec_actual_taken = at; bus.exec_actual_target = atgt; step();
    bus.exec_valid = 1'b0; bus.commit_ready = 1'b1; #1;
    n_chk++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL misp_commit_valid: got %b want 1", bus.commit_valid); end
    step();
    n_chk++; if (bus.flush !== RECOV) begin n_fail++; $display("FAIL misp_flush: got %b want %b", bus.flush, RECOV); end
    n_chk++; if (bus.redirect_pc !== (RECOV ? want_pc : 8'h00)) begin n_fail++; $display("FAIL misp_redirect: got %h want %h", bus.redirect_pc, RECOV ? want_pc : 8'h00); end
    n_chk++; if (bus.alloc_ready !== !RECOV || bus.count !== 4'd0) begin n_fail++; $display("FAIL misp_c1_state: got rdy %b cnt %0d want %b 0", bus.alloc_ready, bus.count, !RECOV); end
    bus.commit_ready = 1'b0; step();
    n_chk++; if (bus.flush !== 1'b0 || bus.alloc_ready !== 1'b1 || bus.count !== 4'd0) begin n_fail++; $display("FAIL misp_c2_state: got fl %b rdy %b cnt %0d want 0 1 0", bus.flush, bus.alloc_ready, bus.count); end
  endtask

  task automatic test_out_of_range_and_reset_in_flush();
    do_reset();
    alloc_plain(3);
    bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'd5; step();
    bus.exec_rob_idx = 3'd3; step();
    bus.exec_valid = 1'b0; #1;
    n_chk++; if (bus.commit_valid !== 1'b0 || bus.count !== 4'd3) begin n_fail++; $display("FAIL oor_ignored: got v %b cnt %0d want 0 3", bus.commit_valid, bus.count); end
    bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'd0; step();
    bus.exec_valid = 1'b0; #1;
    n_chk++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL oor_inrange: got %b want 1", bus.commit_valid); end
    // mispredicted branch, then reset during the flush cycle
    do_reset();
    bus.alloc_valid = 1'b1; p_pc = 8'h10; p_br = 1'b1; p_pt = 1'b0; step();
    bus.alloc_valid = 1'b0; bus.exec_valid = 1'b1; bus.exec_rob_idx = 3'd0;
    bus.exec_actual_taken = 1'b1; bus.exec_actual_target = 8'h40; step();
    bus.exec_valid = 1'b0; bus.commit_ready = 1'b1; step();
    n_chk++; if (bus.flush !== RECOV) begin n_fail++; $display("FAIL rif_flush: got %b want %b", bus.flush, RECOV); end
    bus.commit_ready = 1'b0; rst = 1'b0; step();
    rst = 1'b1; #1;
    n_chk++; if (bus.flush !== 1'b0 || bus.redirect_pc !== 8'h00) begin n_fail++; $display("FAIL rif_flush_clr: got fl %b pc %h want 0 00", bus.flush, bus.redirect_pc); end
    n_chk++; if (bus.alloc_ready !== 1'b1 || bus.commit_valid !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL rif_outputs: got rdy %b cv %b e %b f %b want 1 0 1 0", bus.alloc_ready, bus.commit_valid, bus.empty, bus.full); end
  endtask

  task automatic test_random(input int cycles);
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      rst = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
      bus.alloc_valid  = ($urandom_range(9) < 7);
      bus.commit_ready = ($urandom_range(9) < 7);
      bus.exec_valid   = ($urandom_range(9) < 6);
      if (m_q.size() > 0 && $urandom_range(3) != 0)
        bus.exec_rob_idx = 3'(m_q[$urandom_range(m_q.size() - 1)].idx);
      else
        bus.exec_rob_idx = 3'($urandom_range(DEPTH - 1));
      bus.exec_actual_taken  = 1'($urandom_range(1));
      bus.exec_actual_target = ($urandom_range(1) == 0) ? 8'h40 : 8'($urandom);
      p_pc = 8'($urandom); p_lrd = 5'($urandom); p_prd = 6'($urandom);
      p_st = 1'($urandom_range(1)); p_br = 1'($urandom_range(1));
      p_pt = 1'($urandom_range(1)); p_ptgt = ($urandom_range(1) == 0) ? 8'h40 : 8'($urandom);
      #1;
      n_chk++; if (bus.alloc_ready !== e_alloc_ready()) begin n_fail++; $display("FAIL rnd_alloc_ready c%0d: got %b want %b", c, bus.alloc_ready, e_alloc_ready()); end
      n_chk++; if (bus.rob_write !== (bus.alloc_valid && e_alloc_ready())) begin n_fail++; $display("FAIL rnd_rob_write c%0d: got %b", c, bus.rob_write); end
      n_chk++; if (bus.commit_valid !== e_commit_valid()) begin n_fail++; $display("FAIL rnd_commit_valid c%0d: got %b want %b", c, bus.commit_valid, e_commit_valid()); end
      n_chk++; if (bus.rob_head !== 3'(m_head) || bus.rob_tail !== 3'(m_tail)) begin n_fail++; $display("FAIL rnd_ptrs c%0d: got h %0d t %0d want %0d %0d", c, bus.rob_head, bus.rob_tail, m_head, m_tail); end
      n_chk++; if (bus.count !== 4'(m_q.size()) || bus.empty !== (m_q.size() == 0) || bus.full !== (m_q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.count, m_q.size()); end
      n_chk++; if (bus.flush !== m_fl || bus.redirect_pc !== m_redir) begin n_fail++; $display("FAIL rnd_flush c%0d: got %b %h want %b %h", c, bus.flush, bus.redirect_pc, m_fl, m_redir); end
      if (m_q.size() > 0) begin
        n_chk++; if (bus.commit_logical_rd !== m_q[0].lrd || bus.commit_phys_rd !== m_q[0].prd || bus.commit_is_store !== m_q[0].st) begin n_fail++; $display("FAIL rnd_commit_fields c%0d: got %0d %0d %b want %0d %0d %b", c, bus.commit_logical_rd, bus.commit_phys_rd, bus.commit_is_store, m_q[0].lrd, m_q[0].prd, m_q[0].st); end
      end
      step();
    end
    rst = 1'b1; idle_inputs(); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_pc[i] = '0; mem_lrd[i] = '0; mem_prd[i] = '0; mem_st[i] = 1'b0;
      mem_br[i] = 1'b0; mem_pt[i] = 1'b0; mem_ptgt[i] = '0;
    end
    m_head = 0; m_tail = 0; m_fl = 1'b0; m_redir = 8'h00;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_out_of_order();
    test_full_retire_alloc();
    test_mispredict(1'b0, 8'h00, 1'b1, 8'h40, 8'h40);
    test_mispredict(1'b1, 8'h40, 1'b0, 8'h33, 8'h11);
    test_out_of_range_and_reset_in_flush();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_rob_commit_ctrl
`default_nettype wire

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

Allocation, completion-tracking and retirement controller for the reorder buffer storage array. Drives the storage's `rob_head`, `rob_tail` and `rob_write`, accepts rename-stage allocation requests, and records execution completions and branch outcomes per entry. Retires the head entry in order toward the RAT/free list/store path, and raises a one-cycle flush with a redirect PC when a mispredicted branch retires.

## Interface
- `DEPTH`, default `ROB_LENGTH`: number of ROB entries, any value ≥ 2.
- `IDX_W`, default `ROB_IDX_W`: entry index width, ≥ clog2(DEPTH).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `alloc_valid` in 1: rename requests one entry.
- `alloc_ready` out 1: entry can be allocated this cycle.
- `rob_write` out 1: `alloc_valid & alloc_ready`; write strobe to storage.
- `rob_tail` out IDX_W: allocation index; also the index returned to rename.
- `rob_head` out IDX_W: oldest entry index; storage read address.
- `exec_valid` in 1: execution unit completes an entry.
- `exec_rob_idx` in IDX_W: index of the completing entry.
- `exec_actual_taken` in 1: resolved branch direction.
- `exec_actual_target` in INSTR_MEM_IDX_W: resolved branch target.
- `head_pc` in INSTR_MEM_IDX_W: storage head read data.
- `head_logical_rd` in ARCH_REG_IDX_W: storage head read data.
- `head_phys_rd` in PHYS_REG_IDX_W: storage head read data.
- `head_is_store` in 1: storage head read data.
- `head_is_branch` in 1: storage head read data.
- `head_pred_taken` in 1: storage head read data.
- `head_pred_target` in INSTR_MEM_IDX_W: storage head read data.
- `commit_valid` out 1: head entry is retireable.
- `commit_ready` in 1: consumer accepts retirement.
- `commit_logical_rd` out ARCH_REG_IDX_W: pass-through of the head field.
- `commit_phys_rd` out PHYS_REG_IDX_W: pass-through of the head field.
- `commit_is_store` out 1: pass-through of the head field.
- `flush` out 1: pipeline flush pulse.
- `redirect_pc` out INSTR_MEM_IDX_W: fetch target, valid while `flush` is high.
- `count` out IDX_W+1: number of occupied entries.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.

## Operation
- State is `head`, `tail`, `count`, a per-entry `done` bit vector, and per-entry `act_taken`/`act_target`. The FSM has two states, RUN and FLUSH.
- Allocation:
  - `alloc_ready = (state == RUN) & ~full`.
  - On `rob_write`, `done[tail]` is cleared and `tail` advances modulo DEPTH (DEPTH-1 → 0).
- Completion:
  - Applies when `exec_valid` is high in RUN and `exec_rob_idx` is in flight, i.e. `(exec_rob_idx - head) mod DEPTH < count`.
  - Sets `done[exec_rob_idx]` and stores `act_taken`/`act_target` for that entry.
  - Out-of-range completions are ignored.
- Commit:
  - `commit_valid = (state == RUN) & ~empty & done[head]`.
  - A retirement fires when `commit_valid & commit_ready`; `head` then advances modulo DEPTH.
  - `commit_*` outputs are combinational pass-throughs of the `head_*` fields.
- Count:
  - Allocation alone: +1. Retirement alone: −1. Both in the same cycle: unchanged.
- Mispredict:
  - A retiring entry mispredicted when `head_is_branch` and (`act_taken != head_pred_taken`, or `act_taken` and `act_target != head_pred_target`).
  - The mispredicted entry still retires (its `commit_valid` handshake completes).
  - At that clock edge: `head`, `tail` and `count` are set to 0, `done` is cleared, and the FSM enters FLUSH.
  - `redirect_pc` is registered as `act_target` if taken, else `head_pc + 1` (PC is a word index).
- FLUSH lasts exactly one cycle, then the FSM returns to RUN.
  - `flush = 1` only in FLUSH.
  - In FLUSH: no allocation, completion or commit is performed.
- Reset (`rst == 0` at a clock edge): state RUN; `head`, `tail`, `count` = 0; `done` cleared.
  - Output values after reset: `flush = 0`, `redirect_pc = 0`, `alloc_ready = 1`, `commit_valid = 0`, `empty = 1`, `full = 0`.
  - Reset asserted during FLUSH abandons the flush.

## Timing
- Allocation to visibility: an entry written at edge T is counted from cycle T+1.
- Completion to commit: a completion at edge T can retire at the earliest in cycle T+1.
  - A completion of the head entry and its commit never occur in the same cycle.
- `alloc_ready` depends only on registered state, so it has no combinational path from `commit_ready`.
  - When full, a same-cycle retirement does not enable allocation; allocation resumes the next cycle.
- Mispredicted retirement in cycle T gives `flush = 1` in cycle T+1 and `alloc_ready = 1` in cycle T+2.

## Configuration
- `ROB_BRANCH_RECOVERY_EN` defined: mispredict detection, the FLUSH state, and `act_taken`/`act_target` storage are compiled in.
- `ROB_BRANCH_RECOVERY_EN` undefined:
  - `flush` is tied to 0 and `redirect_pc` to `'0`; the FSM stays in RUN.
  - The `exec_actual_*` inputs are ignored and branches retire like any other entry.

## Structure
- In `general_defines`:
  - existing `ROB_LENGTH` and `ROB_IDX_W`;
  - new enum `rob_cmt_state_t` {RUN, FLUSH};
  - new `rob_cnt_t` (`logic [ROB_IDX_W:0]`).
- Sub-module `rob_ptr_ctr` is instantiated twice, for head and tail. It is a modulo-DEPTH pointer with `inc` and `clr` inputs, where `clr` has priority over `inc`.

## Test plan
All scenarios use DEPTH = 8.
- Allocate 8 with `commit_ready = 0` → `full = 1`, `alloc_ready = 0`, `count = 8`, `rob_tail = 0` after wrap.
- Complete indices 2, 1, 0 out of order with `commit_ready = 1` → retirements at heads 0, 1, 2 in order, one per cycle, starting the cycle after index 0 completes.
- Full ROB with head completed, `alloc_valid = 1` and `commit_ready = 1` → cycle 1: retire only, `count = 7`; cycle 2: allocation accepted at index 0.
- Branch at `head_pc = 0x10` with predicted not-taken, resolved taken to 0x40 → retires, next cycle `flush = 1` and `redirect_pc = 0x40`, then `count = 0` and `alloc_ready = 1`.
- Predicted taken to 0x40, resolved not-taken, `head_pc = 0x10` → `redirect_pc = 0x11`.
- `exec_rob_idx = 5` with `count = 3` and `head = 0` → ignored; `rst = 0` during FLUSH → `flush = 0` on the next cycle and all outputs at reset values.
